// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave): single outstanding request, one response per grant.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, single-outstanding imem handshake, IF/ID slot.
// Optional macro FETCH_ADEL_EN: keeps redirect_pc[1:0] and turns misaligned fetches into a flagged nop.
module fetch_stage #(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall,
   input  logic             redirect_en,
   input  logic [PC_W-1:0]  redirect_pc,
   fetch_stage_if.master    imem,
   output logic             id_valid,
   output logic [31:0]      id_instr,
   output logic [PC_W-1:0]  id_pc8
`ifdef FETCH_ADEL_EN
   ,
   output logic             id_adel
`endif
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t          state_reg;
   logic [PC_W-1:0] pc_reg;
   logic            drop_reg;
   logic            run_reg;
   logic [31:0]     hold_reg;
   logic            req_w;
   logic            granted;
   logic            slot_free;
   logic [PC_W-1:0] target;

`ifdef FETCH_ADEL_EN
   logic            idle_reg;
   logic            misaligned;

   assign misaligned = (pc_reg[1:0] != 2'b00);
   assign target     = redirect_pc;
   // A misaligned PC never reaches memory; the nop/adel path stands in for it.
   assign req_w      = run_reg && (state_reg == S_REQ) && !misaligned;
`else
   assign target     = redirect_pc & ~PC_W'(3);
   assign req_w      = run_reg && (state_reg == S_REQ);
`endif

   assign imem.imem_req  = req_w;
   assign imem.imem_addr = pc_reg;
   assign granted        = req_w && imem.imem_gnt;
   assign slot_free      = !id_valid || !stall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= S_REQ;
         pc_reg    <= RESET_PC;
         drop_reg  <= 1'b0;
         run_reg   <= 1'b0;
         hold_reg  <= 32'h0;
         id_valid  <= 1'b0;
         id_instr  <= 32'h0;
         id_pc8    <= '0;
`ifdef FETCH_ADEL_EN
         idle_reg  <= 1'b0;
         id_adel   <= 1'b0;
`endif
      end else begin
         run_reg <= 1'b1;

         // ID takes the slot this cycle; any word loaded below overrides this.
         if (id_valid && !stall) begin
            id_valid <= 1'b0;
`ifdef FETCH_ADEL_EN
            id_adel  <= 1'b0;
`endif
         end

         if (redirect_en) begin
            pc_reg   <= target;
            id_valid <= 1'b0;
`ifdef FETCH_ADEL_EN
            id_adel  <= 1'b0;
            idle_reg <= 1'b0;
`endif
            unique case (state_reg)
               S_REQ: begin
                  if (granted) begin
                     state_reg <= S_WAIT;
                     drop_reg  <= 1'b1;
                  end
               end
               S_WAIT: begin
                  // A response landing with the redirect is discarded right here.
                  if (imem.imem_rvalid) begin
                     state_reg <= S_REQ;
                     drop_reg  <= 1'b0;
                  end else begin
                     drop_reg  <= 1'b1;
                  end
               end
               default: state_reg <= S_REQ;
            endcase
         end else begin
            unique case (state_reg)
               S_REQ: begin
`ifdef FETCH_ADEL_EN
                  if (run_reg && misaligned && !idle_reg && slot_free) begin
                     id_instr <= 32'h0;
                     id_pc8   <= pc_reg + PC_W'(8);
                     id_valid <= 1'b1;
                     id_adel  <= 1'b1;
                     idle_reg <= 1'b1;
                  end else
`endif
                  if (granted) begin
                     state_reg <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (imem.imem_rvalid) begin
                     if (drop_reg) begin
                        drop_reg  <= 1'b0;
                        state_reg <= S_REQ;
                     end else if (slot_free) begin
                        id_instr  <= imem.imem_rdata;
                        id_pc8    <= pc_reg + PC_W'(8);
                        id_valid  <= 1'b1;
`ifdef FETCH_ADEL_EN
                        id_adel   <= 1'b0;
`endif
                        pc_reg    <= pc_reg + PC_W'(4);
                        state_reg <= S_REQ;
                     end else begin
                        hold_reg  <= imem.imem_rdata;
                        pc_reg    <= pc_reg + PC_W'(4);
                        state_reg <= S_HOLD;
                     end
                  end
               end
               S_HOLD: begin
                  // pc already points past the buffered word, so its PC+8 is pc+4.
                  if (!stall) begin
                     id_instr  <= hold_reg;
                     id_pc8    <= pc_reg + PC_W'(4);
                     id_valid  <= 1'b1;
`ifdef FETCH_ADEL_EN
                     id_adel   <= 1'b0;
`endif
                     state_reg <= S_REQ;
                  end
               end
               default: state_reg <= S_REQ;
            endcase
         end
      end
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Owns the PC register and runs a single-outstanding request/response handshake to instruction memory.
- Holds the IF/ID slot. Its outputs feed the decoder: id_instr[25:0] and id_pc8 drive the immediate extender's In and PC8 inputs.
- Accepts stall from hazard control and redirect from the NPC/branch unit.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
PC_W, 32, PC and address width (fixed 32 in this core)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
stall  input  1  ID cannot accept; IF/ID slot holds
redirect_en  input  1  one-cycle pulse: branch/jump taken
redirect_pc  input  32  target PC, valid with redirect_en
imem_req  output  1  request valid
imem_addr  output  32  request word address (= pc)
imem_gnt  input  1  request accepted this cycle when imem_req && imem_gnt
imem_rvalid  input  1  response valid, exactly one per granted request, at least 1 cycle after grant
imem_rdata  input  32  instruction word
id_valid  output  1  IF/ID slot holds a live instruction
id_instr  output  32  instruction in IF/ID slot
id_pc8  output  32  slot PC + 8

Behaviour:
- Reset (async, while reset_n=0):
  - pc=RESET_PC, state=REQ, drop=0.
  - id_valid=0, id_instr=0, id_pc8=0, imem_req=0, hold buffer cleared.
- Outputs are registered except imem_req and imem_addr, which decode from state and pc.
- States:
  - REQ: imem_req=1. On gnt -> WAIT. Stays in REQ until granted.
  - WAIT: imem_req=0. Waiting for imem_rvalid.
  - HOLD: response captured in hold buffer while ID is stalled. imem_req=0.
- WAIT, on rvalid:
  - If drop=1: discard the word, drop<=0, -> REQ.
  - Else if slot free (!id_valid || !stall): id_instr<=rdata, id_pc8<=pc+8, id_valid<=1, pc<=pc+4, -> REQ.
  - Else: hold_instr<=rdata, pc<=pc+4, -> HOLD.
- HOLD:
  - When !stall: move buffer to slot, with id_pc8 = (pc-4)+8 (the PC of the buffered instruction plus 8), then -> REQ.
- Slot consumption:
  - When id_valid && !stall and no new word arrives this cycle, id_valid<=0.
  - Arithmetic is modulo 2^32; pc+4 wraps 32'hFFFF_FFFC -> 0.
- Redirect (priority over stall and over any response in the same cycle):
  - pc<=redirect_pc & ~32'h3; id_valid<=0 (flush).
  - In WAIT: drop<=1, unless rvalid arrives this same cycle (that word is discarded and drop stays 0). Next state is REQ once the response is consumed.
  - In HOLD: hold buffer discarded, -> REQ.
  - In REQ with gnt this cycle: -> WAIT with drop<=1.
  - In REQ without gnt: imem_addr switches to the new pc next cycle.
- Latency: first request one cycle after reset release. Zero-wait memory (gnt same cycle, rvalid next cycle) sustains one instruction per 2 cycles.
- Stall holds the slot contents bit-exact. stall and id_valid=0 together have no effect.
- Reset mid-transaction: state and drop cleared. Memory must not return rvalid for a request issued before reset; system reset guarantees this.

Optional Feature:
- Macro FETCH_ADEL_EN.
- Defined:
  - redirect_pc[1:0] is preserved in pc.
  - When pc[1:0]!=0 in REQ: no imem request is issued. The slot is loaded with id_instr=0 (nop), id_valid=1, and output id_adel=1 (extra 1-bit port, reset 0).
  - FSM then idles in REQ with imem_req=0 until the next redirect.
  - id_adel follows the slot (cleared on flush or consumption).
- Not defined: low two bits are forced to 0, and the id_adel port is absent.

Test Plan:
- Reset release, zero-wait memory returning 32'h2408_0005 at 0x3000 -> imem_addr=0x3000. Two cycles later: id_valid=1, id_instr=32'h2408_0005, id_pc8=0x3008. Next request addr=0x3004.
- stall=1 for 5 cycles while a response arrives -> FSM enters HOLD, slot unchanged. On stall release the buffered word appears with id_pc8=0x300C. No lost or duplicated instruction.
- redirect_en with redirect_pc=0x3100 while in WAIT, rvalid 3 cycles later -> returned word dropped, id_valid=0, next imem_addr=0x3100.
- redirect_en coincident with stall=1 and id_valid=1 -> slot flushed (id_valid=0) the next cycle; redirect wins.
- imem_gnt held low for 4 cycles -> imem_req and imem_addr stable throughout, no state advance. Also: pc=0xFFFF_FFFC fetch -> next addr=0x0000_0000.
- FETCH_ADEL_EN, redirect_pc=0x3102 -> no imem_req, id_instr=0, id_adel=1, id_pc8=0x310A. Idles until redirect to 0x3000.
